// File: rtl/life_if.sv
// life_if: control, display-read and status bundle for life_board_engine.
interface life_if #(
  parameter int BIT_WIDTH  = 3,
  parameter int BIT_HEIGHT = 3
);
  logic                           run;
  logic                           frame_tick;
  logic                           step;
  logic                           seed_load;
  logic [BIT_WIDTH-1:0]           rd_x;
  logic [BIT_HEIGHT-1:0]          rd_y;
  logic                           rd_cell;
  logic                           busy;
  logic                           gen_done;
  logic [15:0]                    gen_count;
  logic [BIT_WIDTH+BIT_HEIGHT:0]  population;
  modport master (
    output run, frame_tick, step, seed_load, rd_x, rd_y,
    input  rd_cell, busy, gen_done, gen_count, population
  );
  modport slave (
    input  run, frame_tick, step, seed_load, rd_x, rd_y,
    output rd_cell, busy, gen_done, gen_count, population
  );
endinterface

// File: rtl/life_board_engine.sv
// life_board_engine: Game of Life (B3/S23) engine, one cell per cycle from a snapshot board.
// Define LIFE_WRAP_EN for a toroidal board; otherwise off-board neighbours are dead.
module life_board_engine #(
  parameter int BIT_WIDTH  = 3,
  parameter int BIT_HEIGHT = 3,
  parameter logic [2**(BIT_WIDTH+BIT_HEIGHT)-1:0] SEED = '0
) (
  input logic   clk,
  input logic   reset,
  life_if.slave bus
);
  localparam int IW = BIT_WIDTH + BIT_HEIGHT;
  localparam int N  = 2**IW;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EVAL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]            state;
  logic [N-1:0]          cur, prev;
  logic [IW-1:0]         idx;
  logic [IW:0]           acc, population;
  logic [15:0]           gen_count;
  logic [BIT_WIDTH-1:0]  x, nx;
  logic [BIT_HEIGHT-1:0] y, ny;
  logic [3:0]            nbr;
  logic                  ok, new_cell, start;
  assign x = idx[BIT_WIDTH-1:0];
  assign y = idx[IW-1:BIT_WIDTH];
  // Coordinates wrap naturally in their own width; the flat build masks the off-board ones.
  always_comb begin
    nbr = '0;
    nx  = '0;
    ny  = '0;
    ok  = 1'b0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (dx != 0 || dy != 0) begin
          nx = x + BIT_WIDTH'(dx);
          ny = y + BIT_HEIGHT'(dy);
`ifdef LIFE_WRAP_EN
          ok = 1'b1;
`else
          ok = !((dx < 0 && x == '0) || (dx > 0 && x == '1) ||
                 (dy < 0 && y == '0) || (dy > 0 && y == '1));
`endif
          nbr = nbr + 4'(ok & prev[{ny, nx}]);
        end
  end
  assign new_cell = prev[idx] ? (nbr == 4'd2 || nbr == 4'd3) : (nbr == 4'd3);
  assign start    = (bus.frame_tick & bus.run) | bus.step;
  always_ff @(posedge clk) begin
    if (reset) begin
      cur        <= SEED;
      prev       <= '0;
      state      <= IDLE;
      idx        <= '0;
      acc        <= '0;
      gen_count  <= '0;
      population <= '0;
    end else if (state == IDLE) begin
      if (bus.seed_load) begin
        cur        <= SEED;
        gen_count  <= '0;
        population <= '0;
      end else if (start) begin
        prev  <= cur;
        idx   <= '0;
        acc   <= '0;
        state <= EVAL;
      end
    end else if (state == EVAL) begin
      cur[idx] <= new_cell;
      acc      <= acc + (IW+1)'(new_cell);
      idx      <= idx + IW'(1);
      if (idx == '1) state <= DONE;
    end else begin
      population <= acc;
      gen_count  <= gen_count + 16'd1;
      state      <= IDLE;
    end
  end
  assign bus.busy       = state != IDLE;
  assign bus.gen_done   = state == DONE;
  assign bus.gen_count  = gen_count;
  assign bus.population = population;
  assign bus.rd_cell    = bus.busy ? prev[{bus.rd_y, bus.rd_x}] : cur[{bus.rd_y, bus.rd_x}];
endmodule

// File: tb/tb_life_board_engine.sv
// tb_life_board_engine: four engines with different seeds, shared stimulus, board-level reference model.
module tb_life_board_engine;
  localparam int W = 8, H = 8, N = 64, NI = 4;
  localparam logic [NI-1:0][63:0] SEEDS = {
    64'h3C5A_81E7_0F99_24D6,
    64'h0000_0001_0101_0000,
    64'h0000_0000_0006_0600,
    64'h0000_0008_0808_0000
  };
`ifdef LIFE_WRAP_EN
  localparam logic [63:0] EDGE_NEXT = 64'h0000_0000_8300_0000;
  localparam logic [63:0] EDGE_POP  = 64'd3;
`else
  localparam logic [63:0] EDGE_NEXT = 64'h0000_0000_0300_0000;
  localparam logic [63:0] EDGE_POP  = 64'd2;
`endif
  logic clk = 0, reset = 1, run = 0, frame_tick = 0, step = 0, seed_load = 0;
  logic [2:0] rd_x = 0, rd_y = 0;
  logic busy_a[NI], done_a[NI], cell_a[NI];
  logic [15:0] gc_a[NI];
  logic [6:0] pop_a[NI];
  int checks = 0, errors = 0, done_cnt = 0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : u
    life_if #(.BIT_WIDTH(3), .BIT_HEIGHT(3)) bus ();
    assign bus.run        = run;
    assign bus.frame_tick = frame_tick;
    assign bus.step       = step;
    assign bus.seed_load  = seed_load;
    assign bus.rd_x       = rd_x;
    assign bus.rd_y       = rd_y;
    life_board_engine #(.BIT_WIDTH(3), .BIT_HEIGHT(3), .SEED(SEEDS[g])) dut (
      .clk(clk), .reset(reset), .bus(bus)
    );
    assign busy_a[g] = bus.busy;
    assign done_a[g] = bus.gen_done;
    assign cell_a[g] = bus.rd_cell;
    assign gc_a[g]   = bus.gen_count;
    assign pop_a[g]  = bus.population;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] life(input logic [63:0] b);
    logic [63:0] r;
    int n, xx, yy;
    r = '0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            if (dx == 0 && dy == 0) continue;
            xx = x + dx;
            yy = y + dy;
`ifdef LIFE_WRAP_EN
            xx = (xx + W) % W;
            yy = (yy + H) % H;
`else
            if (xx < 0 || xx >= W || yy < 0 || yy >= H) continue;
`endif
            n += int'(b[yy*W+xx]);
          end
        r[y*W+x] = (n == 3) || (b[y*W+x] && n == 2);
      end
    return r;
  endfunction

  // Model: ph = 0 idle, 1..N evaluating, N+1 completion cycle.
  logic [63:0] mc[NI], mp[NI], mn[NI], shown;
  logic [6:0]  mpop[NI];
  logic [15:0] mgc = 0;
  int ph = 0;
  bit started = 0;
  always @(posedge clk) begin
    if (reset) begin
      for (int g = 0; g < NI; g++) begin
        mc[g] = SEEDS[g]; mp[g] = '0; mpop[g] = '0;
      end
      ph = 0; mgc = 0; started = 1;
    end else if (ph == 0) begin
      if (seed_load) begin
        for (int g = 0; g < NI; g++) begin mc[g] = SEEDS[g]; mpop[g] = '0; end
        mgc = 0;
      end else if ((frame_tick && run) || step) begin
        for (int g = 0; g < NI; g++) begin mp[g] = mc[g]; mn[g] = life(mc[g]); end
        ph = 1;
      end
    end else if (ph <= N) ph++;
    else begin
      for (int g = 0; g < NI; g++) begin mc[g] = mn[g]; mpop[g] = 7'($countones(mn[g])); end
      mgc++;
      ph = 0;
    end
    #2;
    if (started)
      for (int g = 0; g < NI; g++) begin
        shown = (ph != 0) ? mp[g] : mc[g];
        check($sformatf("busy[%0d]", g), 64'(busy_a[g]), 64'(ph != 0));
        check($sformatf("gen_done[%0d]", g), 64'(done_a[g]), 64'(ph == N + 1));
        check($sformatf("gen_count[%0d]", g), 64'(gc_a[g]), 64'(mgc));
        check($sformatf("population[%0d]", g), 64'(pop_a[g]), 64'(mpop[g]));
        check($sformatf("rd_cell[%0d]@%0d,%0d", g, rd_x, rd_y), 64'(cell_a[g]), 64'(shown[{rd_y, rd_x}]));
      end
    if (done_a[0]) done_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      rd_x = 3'($urandom);
      rd_y = 3'($urandom);
    end
  endtask

  logic [63:0] brd[NI];
  task automatic read_boards();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      rd_x = 3'(i % W);
      rd_y = 3'(i / W);
      #1;
      for (int g = 0; g < NI; g++) brd[g][i] = cell_a[g];
    end
  endtask

  int k, d0;
  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    check("reset_busy", 64'(busy_a[0]), 64'd0);
    check("reset_gen_count", 64'(gc_a[0]), 64'd0);
    cyc(3);
    // single step, with ignored requests while busy and a prev-board read
    d0 = done_cnt;
    step = 1;
    k = 0;
    while (!done_a[0] && k < 200) begin
      @(negedge clk);
      k++;
      rd_x = 3'($urandom); rd_y = 3'($urandom);
      step = (k == 10);
      frame_tick = (k == 10);
      if (k == 10) begin rd_x = 3; rd_y = 2; end
      if (k == 11) begin
        check("busy_rd_prev", 64'(cell_a[0]), 64'd1);
        check("busy_mid", 64'(busy_a[0]), 64'd1);
      end
    end
    step = 0; frame_tick = 0;
    check("step_latency", 64'(k), 64'd65);
    cyc(20);
    check("single_done_pulse", 64'(done_cnt - d0), 64'd1);
    check("gen_count_1", 64'(gc_a[0]), 64'd1);
    check("blinker_pop", 64'(pop_a[0]), 64'd3);
    check("edge_pop", 64'(pop_a[2]), EDGE_POP);
    check("model_blinker", mc[0], 64'h0000_0000_1C00_0000);
    check("model_edge", mc[2], EDGE_NEXT);
    read_boards();
    check("board_blinker", brd[0], 64'h0000_0000_1C00_0000);
    check("board_block", brd[1], 64'h0000_0000_0006_0600);
    check("board_edge", brd[2], EDGE_NEXT);
    // reset in the middle of evaluation
    d0 = done_cnt;
    @(negedge clk);
    step = 1;
    for (k = 1; k <= 31; k++) begin
      @(negedge clk);
      step = 0;
      reset = (k == 30);
    end
    check("abort_busy", 64'(busy_a[0]), 64'd0);
    check("abort_gen_count", 64'(gc_a[0]), 64'd0);
    cyc(100);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    read_boards();
    check("abort_board_seed", brd[0], SEEDS[0]);
    // free-run with five frame ticks
    run = 1;
    repeat (5) begin
      @(negedge clk); frame_tick = 1;
      @(negedge clk); frame_tick = 0;
      cyc(98);
    end
    run = 0;
    cyc(5);
    check("run_gen_count", 64'(gc_a[1]), 64'd5);
    check("block_pop", 64'(pop_a[1]), 64'd4);
    read_boards();
    check("block_still", brd[1], 64'h0000_0000_0006_0600);
    // seed_load beats a simultaneous step
    @(negedge clk); seed_load = 1; step = 1;
    @(negedge clk); seed_load = 0; step = 0;
    check("seed_load_busy", 64'(busy_a[0]), 64'd0);
    check("seed_load_gen_count", 64'(gc_a[0]), 64'd0);
    cyc(3);
    check("seed_load_idle", 64'(busy_a[0]), 64'd0);
    read_boards();
    check("seed_load_board", brd[3], SEEDS[3]);
    // randomized traffic
    repeat (3000) begin
      @(negedge clk);
      rd_x = 3'($urandom); rd_y = 3'($urandom);
      step = ($urandom_range(0, 40) == 0);
      frame_tick = ($urandom_range(0, 25) == 0);
      seed_load = ($urandom_range(0, 200) == 0);
      reset = ($urandom_range(0, 800) == 0);
      if ($urandom_range(0, 100) == 0) run = ~run;
    end
    step = 0; frame_tick = 0; seed_load = 0; reset = 0; run = 0;
    cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
